// File: rtl/bit_count_pkg.sv
// Shared types for the ASM bit counter: controller state encoding and count-mode codes.
package bit_count_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CNT  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] MODE_ONES  = 2'b00;
   localparam logic [1:0] MODE_ZEROS = 2'b01;
   localparam logic [1:0] MODE_LZ    = 2'b10;
   localparam logic [1:0] MODE_TZ    = 2'b11;

endpackage

// File: rtl/bit_count_dp.sv
// Bit counter datapath: operand shift register, index counter, result counter and stop flag.
module bit_count_dp
   import bit_count_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rs,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] ina,
   input  logic [1:0]       mode,
   output logic [CNT_W-1:0] cnt,
   output logic             stop
);

   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic [WIDTH-1:0] a;
   logic [CNT_W-1:0] idx;
   logic [1:0]       mode_r;

   always_ff @(posedge clk or posedge rs) begin
      if (rs) begin
         a      <= '0;
         idx    <= '0;
         cnt    <= '0;
         mode_r <= MODE_ONES;
      end else if (load) begin
         mode_r <= mode;
         a      <= (mode == MODE_ZEROS) ? ~ina : ina;
         idx    <= '0;
         cnt    <= '0;
      end else if (step) begin
         case (mode_r)
            MODE_ONES, MODE_ZEROS: begin
               cnt <= cnt + CNT_W'(a[0]);
               a   <= a >> 1;
            end
            MODE_LZ: begin
               cnt <= cnt + ONE_C;
               a   <= a << 1;
               idx <= idx + ONE_C;
            end
            default: begin
               cnt <= cnt + ONE_C;
               a   <= a >> 1;
               idx <= idx + ONE_C;
            end
         endcase
      end
   end

   // idx bound only matters for an all-zero operand in the leading/trailing modes
   always_comb begin
      stop = 1'b0;
      case (mode_r)
         MODE_ONES, MODE_ZEROS: stop = (a == '0);
         MODE_LZ:               stop = a[WIDTH-1] || (idx == WIDTH_C);
         default:               stop = a[0] || (idx == WIDTH_C);
      endcase
   end

endmodule

// File: rtl/bit_count_asm.sv
// ASM-chart bit counter: ones, zeros, leading or trailing zeros of a WIDTH-bit operand.
//   state  | meaning
//   S_IDLE | waiting for s; result of the previous count held on out
//   S_CNT  | datapath steps one bit per cycle until the stop flag rises
//   S_DONE | result valid, done high; leaves once s is released
module bit_count_asm
   import bit_count_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rs,
   input  logic             s,
   input  logic [WIDTH-1:0] inA,
   input  logic [1:0]       mode,
   output logic [CNT_W-1:0] out,
   output logic             busy,
   output logic             done
);

   state_t state_q;
   state_t state_d;
   logic   load;
   logic   step;
   logic   stop;

   always_ff @(posedge clk or posedge rs) begin
      if (rs) state_q <= S_IDLE;
      else    state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (s) begin
               load    = 1'b1;
               state_d = S_CNT;
            end
         end
         S_CNT: begin
            if (stop) state_d = S_DONE;
            else      step    = 1'b1;
         end
         S_DONE: begin
            if (!s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q == S_CNT);
   assign done = (state_q == S_DONE);

   bit_count_dp #(.WIDTH(WIDTH)) u_dp (
      .clk  (clk),
      .rs   (rs),
      .load (load),
      .step (step),
      .ina  (inA),
      .mode (mode),
      .cnt  (out),
      .stop (stop)
   );

endmodule

// File: tb/tb_bit_count_asm.sv
// Directed bench for bit_count_asm: 8-bit and 16-bit instances with a result/latency scoreboard.
module tb_bit_count_asm;
   import bit_count_pkg::*;

   logic        clk = 1'b0;
   logic        rs;
   logic        s;
   logic [7:0]  ina;
   logic [1:0]  mode;
   logic [3:0]  out;
   logic        busy;
   logic        done;
   logic        s16;
   logic [15:0] ina16;
   logic [1:0]  mode16;
   logic [4:0]  out16;
   logic        busy16;
   logic        done16;

   typedef struct {
      int    res;
      int    lat;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   bit_count_asm #(.WIDTH(8)) dut (
      .clk(clk), .rs(rs), .s(s), .inA(ina), .mode(mode),
      .out(out), .busy(busy), .done(done)
   );

   bit_count_asm #(.WIDTH(16)) dut16 (
      .clk(clk), .rs(rs), .s(s16), .inA(ina16), .mode(mode16),
      .out(out16), .busy(busy16), .done(done16)
   );

   function automatic int model_res(input logic [1:0] m, input logic [15:0] v, input int w);
      int n = 0;
      case (m)
         2'b00: for (int i = 0; i < w; i++) if (v[i]) n++;
         2'b01: for (int i = 0; i < w; i++) if (!v[i]) n++;
         2'b10: for (int i = w - 1; i >= 0; i--) begin
            if (v[i]) break;
            n++;
         end
         default: for (int i = 0; i < w; i++) begin
            if (v[i]) break;
            n++;
         end
      endcase
      return n;
   endfunction

   function automatic int model_lat(input logic [1:0] m, input logic [15:0] v, input int w);
      int hi = -1;
      if (m[1]) return model_res(m, v, w) + 1;
      for (int i = 0; i < w; i++) begin
         if ((m == 2'b01) ? !v[i] : v[i]) hi = i;
      end
      return (hi < 0) ? 1 : hi + 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // drop_after > 0 releases s that many cycles into the count; otherwise s is held
   // for hold_after cycles past done before release.
   task automatic run8(input string tag, input logic [1:0] m, input logic [7:0] v,
                       input int drop_after, input bit perturb, input int hold_after);
      exp_t e;
      int   busy_n = 0;
      bit   got = 1'b0;
      e.res = model_res(m, {8'h00, v}, 8);
      e.lat = model_lat(m, {8'h00, v}, 8);
      e.tag = tag;
      sb.push_back(e);
      @(negedge clk);
      ina  = v;
      mode = m;
      s    = 1'b1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
         if (busy) busy_n++;
         if (perturb) begin
            ina  = 8'($urandom);
            mode = 2'($urandom_range(3, 0));
         end
         if (cyc == drop_after) s = 1'b0;
      end
      e = sb.pop_front();
      check({e.tag, "/done_seen"}, 32'(got), 32'd1);
      check({e.tag, "/out"}, 32'(out), 32'(e.res));
      check({e.tag, "/busy_cycles"}, 32'(busy_n), 32'(e.lat));
      if (drop_after > 0) begin
         @(negedge clk);
         check({e.tag, "/done_one_cycle"}, 32'(done), 32'd0);
         check({e.tag, "/idle_busy"}, 32'(busy), 32'd0);
      end else begin
         repeat (hold_after) @(negedge clk);
         check({e.tag, "/done_held"}, 32'(done), 32'd1);
         check({e.tag, "/no_restart"}, 32'(busy), 32'd0);
         s = 1'b0;
         @(negedge clk);
         check({e.tag, "/idle_done"}, 32'(done), 32'd0);
      end
      @(negedge clk);
      check({e.tag, "/out_held_idle"}, 32'(out), 32'(e.res));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e16;
      int   busy_n;
      bit   got;

      rs = 1'b1; s = 1'b0; ina = '0; mode = '0;
      s16 = 1'b0; ina16 = '0; mode16 = '0;
      repeat (2) @(negedge clk);
      check("reset/out", 32'(out), 32'd0);
      check("reset/busy", 32'(busy), 32'd0);
      check("reset/done", 32'(done), 32'd0);
      check("reset/out16", 32'(out16), 32'd0);
      rs = 1'b0;

      // reset in the middle of a count
      @(negedge clk);
      ina = 8'hFF; mode = MODE_ONES; s = 1'b1;
      repeat (3) @(negedge clk);
      check("abort/busy_before", 32'(busy), 32'd1);
      rs = 1'b1; s = 1'b0;
      #1;
      check("abort/state", 32'(dut.state_q), 32'(S_IDLE));
      check("abort/out", 32'(out), 32'd0);
      check("abort/busy", 32'(busy), 32'd0);
      check("abort/done", 32'(done), 32'd0);
      check("abort/a", 32'(dut.u_dp.a), 32'd0);
      check("abort/idx", 32'(dut.u_dp.idx), 32'd0);
      @(negedge clk);
      rs = 1'b0;
      repeat (2) @(negedge clk);
      check("abort/stay_idle", 32'(busy), 32'd0);

      run8("ones_af", MODE_ONES, 8'b10101111, -1, 1'b0, 3);
      run8("ones_ef", MODE_ONES, 8'b11101111, -1, 1'b0, 1);
      run8("zeros_ef", MODE_ZEROS, 8'b11101111, -1, 1'b0, 1);
      run8("ones_00", MODE_ONES, 8'h00, -1, 1'b0, 1);
      run8("lz_0f", MODE_LZ, 8'h0F, -1, 1'b0, 1);
      run8("lz_00", MODE_LZ, 8'h00, -1, 1'b0, 1);
      run8("tz_28", MODE_TZ, 8'h28, -1, 1'b0, 1);
      run8("tz_80_drop", MODE_TZ, 8'h80, 2, 1'b0, 0);
      run8("ones_b6_perturb", MODE_ONES, 8'hB6, -1, 1'b1, 1);
      run8("lz_13_perturb", MODE_LZ, 8'h13, 3, 1'b1, 0);
      run8("zeros_ff", MODE_ZEROS, 8'hFF, -1, 1'b0, 1);
      run8("tz_00", MODE_TZ, 8'h00, -1, 1'b0, 1);
      for (int k = 0; k < 8; k++) begin
         run8("rand", 2'(k % 4), 8'($urandom), -1, 1'b0, 1);
      end

      // 16-bit instance, s held well past done
      e16.res = model_res(MODE_ONES, 16'hFFFF, 16);
      e16.lat = model_lat(MODE_ONES, 16'hFFFF, 16);
      e16.tag = "w16_ones_ffff";
      sb.push_back(e16);
      @(negedge clk);
      ina16 = 16'hFFFF; mode16 = MODE_ONES; s16 = 1'b1;
      busy_n = 0; got = 1'b0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         if (done16) begin
            got = 1'b1;
            break;
         end
         if (busy16) busy_n++;
      end
      e16 = sb.pop_front();
      check({e16.tag, "/done_seen"}, 32'(got), 32'd1);
      check({e16.tag, "/out"}, 32'(out16), 32'(e16.res));
      check({e16.tag, "/busy_cycles"}, 32'(busy_n), 32'(e16.lat));
      repeat (5) @(negedge clk);
      check({e16.tag, "/done_held"}, 32'(done16), 32'd1);
      check({e16.tag, "/no_restart"}, 32'(busy16), 32'd0);
      s16 = 1'b0;
      repeat (2) @(negedge clk);
      check({e16.tag, "/idle_done"}, 32'(done16), 32'd0);
      check({e16.tag, "/out_held_idle"}, 32'(out16), 32'(e16.res));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
